frame_deframer: RTL and testbench
=================================

# frame_deframer

Receive-side stage directly downstream of the framer. It consumes the framer's byte stream (`frame_valid`/`frame_data`) and hunts for the sync marker. It then parses the header, forwards payload bytes, checks the trailing CRC-16, and reports per-frame status. It also checks sequence continuity of `txfn` and enforces an inter-byte gap timeout, so stalled or truncated frames are aborted rather than hung.

## Interface
- `MAX_PAYLOAD`, 1052: largest legal payload_len in bytes (8416 bits).
- `GAP_TIMEOUT`, 16: maximum idle cycles between bytes inside a frame before abort.
- `SYNC_WORD`, 32'h1ACFFC1D: frame sync marker, MSB byte first.
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `frame_valid` in 1: input byte strobe, one byte per asserted cycle.
- `frame_data` in 8: input byte.
- `hdr_valid` out 1: one-cycle pulse when the header is accepted.
- `frame_type` out 2: type from header, held until the next hdr_valid.
- `txfn` out 16: frame number from header, held.
- `payload_len` out 16: length from header, held.
- `payload_valid` out 1: payload byte strobe.
- `payload_data` out 8: payload byte.
- `frame_ok` out 1: one-cycle pulse; frame complete with CRC good.
- `frame_err` out 1: one-cycle pulse; frame aborted or CRC bad.
- `err_code` out 3: valid with frame_err, held until the next frame_err. Codes: 1=CRC, 2=LEN, 3=TYPE, 4=TIMEOUT.
- `seq_err` out 1: valid with frame_ok; txfn ≠ previous good txfn+1 (mod 2^16).
- `ok_cnt`, `err_cnt` out 16 each: saturating counters of frame_ok and frame_err pulses.

## Operation
- Wire format, bytes MSB first:
  - 4 sync bytes.
  - TYPE byte: bits[1:0]=frame_type, bits[7:2] must be 0.
  - TXFN: 2 bytes.
  - LEN: 2 bytes.
  - LEN payload bytes.
  - CRC: 2 bytes.
- CRC-16-CCITT: poly 0x1021, init 0xFFFF, no reflection, no final XOR. It covers TYPE through the last payload byte.
- FSM: HUNT → HDR → PAYLOAD → CRC → HUNT.
  - HUNT: a 32-bit shift register takes each valid byte. When the register equals SYNC_WORD, go to HDR with a 5-byte count and CRC reset to 0xFFFF.
  - HDR: capture TYPE, TXFN, LEN and update the CRC.
    - After the TYPE byte: if bits[7:2] ≠ 0, abort with TYPE.
    - After the 5th byte: if LEN > MAX_PAYLOAD, abort with LEN.
    - Otherwise pulse hdr_valid. Go to PAYLOAD, or directly to CRC when LEN=0.
  - PAYLOAD: forward each byte and update the CRC. The byte counter counts down from LEN; go to CRC after the last byte.
  - CRC: collect 2 bytes, compare with the computed CRC, then pulse frame_ok or frame_err(CRC). Return to HUNT.
- Abort: pulse frame_err with err_code, clear the sync shift register, return to HUNT.
- Gap timer:
  - Counts cycles with frame_valid=0 in HDR, PAYLOAD and CRC; clears on any valid byte.
  - Reaching GAP_TIMEOUT aborts with TIMEOUT.
  - The timer is inactive in HUNT.
- Sequence check:
  - Compares against the txfn of the last frame_ok.
  - The first good frame after reset never sets seq_err.
  - Frames ending in error do not update the reference.
- Payload bytes are forwarded before the CRC verdict. Consumers discard the frame on frame_err.
- Counters saturate at 0xFFFF.

## Timing
- Reset values:
  - All pulses and strobes 0.
  - frame_type, txfn, payload_len, err_code all 0.
  - seq_err 0; counters 0.
  - State HUNT; sync register 0; gap timer 0.
- hdr_valid: asserted 1 cycle after the 5th header byte is sampled.
- payload_valid/payload_data: registered, 1-cycle latency from input. Input gaps pass through as gaps.
- frame_ok/frame_err: asserted 1 cycle after the 2nd CRC byte is sampled.
- Abort pulses:
  - TYPE abort: 1 cycle after the offending byte.
  - LEN abort: 1 cycle after the 5th header byte.
  - TIMEOUT abort: on the cycle the timer reaches GAP_TIMEOUT.
- Back-to-back frames: a sync byte arriving in the cycle right after the last CRC byte is accepted. HUNT shifts it in, so zero bubbles are needed between frames.
- rst asserted mid-frame: next cycle all outputs take reset values. No frame_err is issued, counters clear, and the sequence reference is forgotten.
- Only one of frame_ok/frame_err is pulsed per frame. err_cnt+ok_cnt increments by exactly 1 per frame outcome.

## Test plan
- **Single good frame.** Sync, TYPE=0x01, TXFN=0x1000, LEN=100, payload bytes 0..99, CRC from the bench model.
  - hdr_valid with type=1, txfn=0x1000, len=100.
  - 100 payload strobes with data 0..99.
  - frame_ok, seq_err=0, ok_cnt=1.
- **Three back-to-back frames, zero gap.**
  - Frames: TXFN 0x1000/LEN 100, TXFN 0x1001/LEN 1052, TXFN 0x1003/LEN 0.
  - Three frame_ok pulses; seq_err=1 only on the third; 1152 payload strobes total.
- **Corrupt CRC.** Payload byte 50 flipped to 0xFF.
  - 100 payload strobes still occur.
  - Then frame_err with err_code=1, err_cnt=1, ok_cnt unchanged.
- **Header errors.**
  - LEN=1053: frame_err with code 2 and no payload strobes.
  - TYPE=0x05: frame_err with code 3 after the TYPE byte.
  - A following good frame is still accepted.
- **Stall mid-payload for 16 cycles:** frame_err with code 4 exactly at the 16th idle cycle. A stall of 15 cycles completes with frame_ok.
- **Noise and reset.**
  - Random bytes containing a partial sync 1A CF FC 00, then a true sync: only the true frame decodes.
  - rst pulsed mid-payload: no frame_err, counters 0, next frame decodes with seq_err=0.

Source files
------------

// File: rtl/frame_deframer_if.sv
// frame_deframer_if: byte-stream input and decoded-frame outputs of the
// receive deframer, bundled as one bus.
//   frame_valid/frame_data           : incoming byte strobe and byte
//   hdr_valid, frame_type, txfn,
//   payload_len                      : header pulse and held header fields
//   payload_valid/payload_data       : forwarded payload bytes
//   frame_ok, frame_err, err_code,
//   seq_err                          : per-frame verdict
//   ok_cnt, err_cnt                  : saturating verdict counters
// Modports: master drives the byte stream, slave is the deframer.
interface frame_deframer_if;
    logic        frame_valid;
    logic [7:0]  frame_data;
    logic        hdr_valid;
    logic [1:0]  frame_type;
    logic [15:0] txfn;
    logic [15:0] payload_len;
    logic        payload_valid;
    logic [7:0]  payload_data;
    logic        frame_ok;
    logic        frame_err;
    logic [2:0]  err_code;
    logic        seq_err;
    logic [15:0] ok_cnt;
    logic [15:0] err_cnt;

    modport master (
        output frame_valid, frame_data,
        input  hdr_valid, frame_type, txfn, payload_len, payload_valid,
               payload_data, frame_ok, frame_err, err_code, seq_err,
               ok_cnt, err_cnt
    );

    modport slave (
        input  frame_valid, frame_data,
        output hdr_valid, frame_type, txfn, payload_len, payload_valid,
               payload_data, frame_ok, frame_err, err_code, seq_err,
               ok_cnt, err_cnt
    );
endinterface

// File: rtl/frame_deframer.sv
// frame_deframer: hunts for the sync marker in the framer byte stream,
// parses the 5-byte header (TYPE, TXFN, LEN), forwards payload bytes,
// checks the trailing CRC-16-CCITT and reports a per-frame verdict.
// An inter-byte gap timer aborts stalled frames; txfn continuity against
// the last good frame is flagged on seq_err.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : frame_deframer_if.slave (byte input, header/payload/verdict out)
module frame_deframer #(
    parameter int          MAX_PAYLOAD = 1052,
    parameter int          GAP_TIMEOUT = 16,
    parameter logic [31:0] SYNC_WORD   = 32'h1ACFFC1D
) (
    input logic              clk,
    input logic              rst,
    frame_deframer_if.slave  bus
);
    localparam int GW = $clog2(GAP_TIMEOUT + 1);

    localparam logic [2:0] ERR_CRC     = 3'd1;
    localparam logic [2:0] ERR_LEN     = 3'd2;
    localparam logic [2:0] ERR_TYPE    = 3'd3;
    localparam logic [2:0] ERR_TIMEOUT = 3'd4;

    typedef enum logic [1:0] {HUNT, HDR, PAYLOAD, CRC} state_t;

    // header fields collected before the header is accepted
    typedef struct packed {
        logic [1:0]  typ;
        logic [15:0] txfn;
        logic [7:0]  len_hi;
    } hdr_t;

    state_t          state_q, state_d;
    logic [31:0]     sync_sr;
    logic [15:0]     crc_q;
    logic [7:0]      crc_hi;
    logic [2:0]      byte_idx;
    logic [15:0]     pay_cnt;
    logic [GW-1:0]   gap_cnt;
    hdr_t            hdr_q;
    logic [15:0]     seq_ref;
    logic            ref_vld;

    logic [31:0]     sync_next;
    logic [15:0]     len_full;
    logic [15:0]     crc_next;
    logic            gap_hit;
    logic            abort;
    logic [2:0]      abort_code;
    logic            hdr_acc;
    logic            fin;
    logic            crc_good;

    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            fb = r[15] ^ d[i];
            r  = {r[14:0], 1'b0};
            if (fb) r = r ^ 16'h1021;
        end
        return r;
    endfunction

    assign sync_next = {sync_sr[23:0], bus.frame_data};
    assign len_full  = {hdr_q.len_hi, bus.frame_data};
    assign crc_next  = crc16_byte(crc_q, bus.frame_data);
    // fires on the idle cycle that would bring the timer to GAP_TIMEOUT,
    // so the registered abort pulse coincides with the timer reaching it
    assign gap_hit   = (state_q != HUNT) && !bus.frame_valid &&
                       (gap_cnt == GW'(GAP_TIMEOUT - 1));

    always_comb begin
        state_d    = state_q;
        abort      = 1'b0;
        abort_code = 3'd0;
        hdr_acc    = 1'b0;
        fin        = 1'b0;
        crc_good   = 1'b0;
        case (state_q)
            HUNT: begin
                if (bus.frame_valid && sync_next == SYNC_WORD) state_d = HDR;
            end
            HDR: begin
                if (gap_hit) begin
                    abort      = 1'b1;
                    abort_code = ERR_TIMEOUT;
                end else if (bus.frame_valid) begin
                    if (byte_idx == 3'd0 && bus.frame_data[7:2] != 6'd0) begin
                        abort      = 1'b1;
                        abort_code = ERR_TYPE;
                    end else if (byte_idx == 3'd4) begin
                        if (len_full > 16'(MAX_PAYLOAD)) begin
                            abort      = 1'b1;
                            abort_code = ERR_LEN;
                        end else begin
                            hdr_acc = 1'b1;
                            state_d = (len_full == 16'd0) ? CRC : PAYLOAD;
                        end
                    end
                end
            end
            PAYLOAD: begin
                if (gap_hit) begin
                    abort      = 1'b1;
                    abort_code = ERR_TIMEOUT;
                end else if (bus.frame_valid && pay_cnt == 16'd1) begin
                    state_d = CRC;
                end
            end
            CRC: begin
                if (gap_hit) begin
                    abort      = 1'b1;
                    abort_code = ERR_TIMEOUT;
                end else if (bus.frame_valid && byte_idx == 3'd1) begin
                    fin      = 1'b1;
                    crc_good = ({crc_hi, bus.frame_data} == crc_q);
                    state_d  = HUNT;
                end
            end
            default: state_d = HUNT;
        endcase
        if (abort) state_d = HUNT;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= HUNT;
            sync_sr           <= '0;
            crc_q             <= '0;
            crc_hi            <= '0;
            byte_idx          <= '0;
            pay_cnt           <= '0;
            gap_cnt           <= '0;
            hdr_q             <= '0;
            seq_ref           <= '0;
            ref_vld           <= 1'b0;
            bus.hdr_valid     <= 1'b0;
            bus.frame_type    <= '0;
            bus.txfn          <= '0;
            bus.payload_len   <= '0;
            bus.payload_valid <= 1'b0;
            bus.payload_data  <= '0;
            bus.frame_ok      <= 1'b0;
            bus.frame_err     <= 1'b0;
            bus.err_code      <= '0;
            bus.seq_err       <= 1'b0;
            bus.ok_cnt        <= '0;
            bus.err_cnt       <= '0;
        end else begin
            bus.hdr_valid     <= 1'b0;
            bus.payload_valid <= 1'b0;
            bus.frame_ok      <= 1'b0;
            bus.frame_err     <= 1'b0;
            state_q           <= state_d;

            if (state_q == HUNT || bus.frame_valid || abort) gap_cnt <= '0;
            else                                              gap_cnt <= gap_cnt + GW'(1);

            case (state_q)
                HUNT: begin
                    if (bus.frame_valid) begin
                        // clear on a hit so stale marker bytes cannot match
                        // again once the frame ends
                        if (sync_next == SYNC_WORD) begin
                            sync_sr  <= '0;
                            crc_q    <= 16'hFFFF;
                            byte_idx <= '0;
                        end else begin
                            sync_sr  <= sync_next;
                        end
                    end
                end
                HDR: begin
                    if (bus.frame_valid && !abort) begin
                        crc_q    <= crc_next;
                        byte_idx <= byte_idx + 3'd1;
                        case (byte_idx)
                            3'd0:    hdr_q.typ         <= bus.frame_data[1:0];
                            3'd1:    hdr_q.txfn[15:8]  <= bus.frame_data;
                            3'd2:    hdr_q.txfn[7:0]   <= bus.frame_data;
                            3'd3:    hdr_q.len_hi      <= bus.frame_data;
                            default: ;
                        endcase
                        if (hdr_acc) begin
                            bus.hdr_valid   <= 1'b1;
                            bus.frame_type  <= hdr_q.typ;
                            bus.txfn        <= hdr_q.txfn;
                            bus.payload_len <= len_full;
                            pay_cnt         <= len_full;
                            byte_idx        <= '0;
                        end
                    end
                end
                PAYLOAD: begin
                    if (bus.frame_valid) begin
                        bus.payload_valid <= 1'b1;
                        bus.payload_data  <= bus.frame_data;
                        crc_q             <= crc_next;
                        pay_cnt           <= pay_cnt - 16'd1;
                    end
                end
                CRC: begin
                    if (bus.frame_valid) begin
                        crc_hi   <= bus.frame_data;
                        byte_idx <= byte_idx + 3'd1;
                        if (fin) begin
                            byte_idx <= '0;
                            if (crc_good) begin
                                bus.frame_ok <= 1'b1;
                                bus.seq_err  <= ref_vld && (bus.txfn != seq_ref + 16'd1);
                                seq_ref      <= bus.txfn;
                                ref_vld      <= 1'b1;
                                if (bus.ok_cnt != 16'hFFFF) bus.ok_cnt <= bus.ok_cnt + 16'd1;
                            end else begin
                                bus.frame_err <= 1'b1;
                                bus.err_code  <= ERR_CRC;
                                if (bus.err_cnt != 16'hFFFF) bus.err_cnt <= bus.err_cnt + 16'd1;
                            end
                        end
                    end
                end
                default: ;
            endcase

            if (abort) begin
                bus.frame_err <= 1'b1;
                bus.err_code  <= abort_code;
                sync_sr       <= '0;
                if (bus.err_cnt != 16'hFFFF) bus.err_cnt <= bus.err_cnt + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_frame_deframer.sv
// tb_frame_deframer: directed frames through frame_deframer. Each frame is
// built from its fields; the bench derives the expected header event,
// payload bytes, verdict and the exact cycle of each from the wire-format
// rules, and a negedge monitor compares every DUT pulse against them.
module tb_frame_deframer;
    localparam int          MAXP = 1052;
    localparam int          GAP  = 16;
    localparam logic [31:0] SYNC = 32'h1ACFFC1D;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    frame_deframer_if bus ();

    frame_deframer #(.MAX_PAYLOAD(MAXP), .GAP_TIMEOUT(GAP), .SYNC_WORD(SYNC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct { int cyc; logic [1:0] typ; logic [15:0] fn; logic [15:0] len; } hdr_e_t;
    typedef struct { int cyc; logic [7:0] d; } pl_e_t;
    typedef struct { int cyc; bit ok; logic [2:0] code; bit seq; int okc; int errc; } out_e_t;

    hdr_e_t hq[$];
    pl_e_t  pq[$];
    out_e_t oq[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int pl_count = 0;

    // frame-level model state
    int          m_ok = 0;
    int          m_err = 0;
    bit          m_have = 0;
    logic [15:0] m_ref = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at cyc %0d", name, act, act, exp, exp, cyc);
        end
    endtask

    // CRC-16-CCITT, MSB-first byte-into-high-half form
    function automatic logic [15:0] m_crc(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c ^ {d, 8'h00};
        for (int i = 0; i < 8; i++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
        return r;
    endfunction

    task automatic tick(input logic v, input logic [7:0] d, output int e);
        bus.frame_valid = v;
        bus.frame_data  = d;
        e = cyc + 1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        int e;
        for (int i = 0; i < n; i++) tick(1'b0, 8'h00, e);
    endtask

    task automatic push_out(input int c, input bit ok, input logic [2:0] code, input bit sq);
        if (ok) begin if (m_ok  < 65535) m_ok++;  end
        else    begin if (m_err < 65535) m_err++; end
        oq.push_back('{c, ok, code, sq, m_ok, m_err});
    endtask

    task automatic do_reset();
        int e;
        rst = 1'b1;
        tick(1'b0, 8'h00, e);
        tick(1'b0, 8'h00, e);
        rst = 1'b0;
        m_ok = 0; m_err = 0; m_have = 0; m_ref = '0;
        chk("rst_hdr_valid", int'(bus.hdr_valid), 0);
        chk("rst_payload_valid", int'(bus.payload_valid), 0);
        chk("rst_frame_ok", int'(bus.frame_ok), 0);
        chk("rst_frame_err", int'(bus.frame_err), 0);
        chk("rst_frame_type", int'(bus.frame_type), 0);
        chk("rst_txfn", int'(bus.txfn), 0);
        chk("rst_payload_len", int'(bus.payload_len), 0);
        chk("rst_err_code", int'(bus.err_code), 0);
        chk("rst_seq_err", int'(bus.seq_err), 0);
        chk("rst_ok_cnt", int'(bus.ok_cnt), 0);
        chk("rst_err_cnt", int'(bus.err_cnt), 0);
    endtask

    // Sends one frame and records what it must produce. Payload byte j is j mod 256.
    // corrupt: payload index sent as 0xFF (CRC field still over true data)
    // stall_at/stall_len: idle cycles inserted before that payload byte
    // rst_at: reset issued instead of sending that payload byte
    task automatic send_frame(input logic [7:0] tb_, input logic [15:0] fn, input logic [15:0] len,
                              input int corrupt, input int stall_at, input int stall_len, input int rst_at);
        logic [7:0]  h [5];
        logic [31:0] sw;
        logic [15:0] c_tx, c_rx;
        logic [7:0]  b, x;
        int          e, last;
        bit          sq;
        sw = SYNC;
        h[0] = tb_; h[1] = fn[15:8]; h[2] = fn[7:0]; h[3] = len[15:8]; h[4] = len[7:0];
        for (int i = 0; i < 4; i++) tick(1'b1, sw[8*(3-i) +: 8], e);
        c_tx = 16'hFFFF;
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, h[i], e);
            c_tx = m_crc(c_tx, h[i]);
            if (i == 0 && h[0][7:2] != 6'd0) begin push_out(e, 1'b0, 3'd3, 1'b0); return; end
            if (i == 4) begin
                if (int'(len) > MAXP) begin push_out(e, 1'b0, 3'd2, 1'b0); return; end
                hq.push_back('{e, h[0][1:0], fn, len});
            end
        end
        c_rx = c_tx;
        last = e;
        for (int j = 0; j < int'(len); j++) begin
            if (j == rst_at) begin do_reset(); return; end
            if (j == stall_at) begin
                for (int k = 0; k < stall_len; k++) begin
                    tick(1'b0, 8'h00, e);
                    if (k == GAP - 1) begin push_out(last + GAP, 1'b0, 3'd4, 1'b0); return; end
                end
            end
            b = 8'(j);
            x = (j == corrupt) ? 8'hFF : b;
            tick(1'b1, x, e);
            last = e;
            pq.push_back('{e, x});
            c_tx = m_crc(c_tx, b);
            c_rx = m_crc(c_rx, x);
        end
        tick(1'b1, c_tx[15:8], e);
        tick(1'b1, c_tx[7:0], e);
        if (c_rx == c_tx) begin
            sq = m_have && (fn != m_ref + 16'd1);
            m_ref = fn; m_have = 1'b1;
            push_out(e, 1'b1, 3'd0, sq);
        end else begin
            push_out(e, 1'b0, 3'd1, 1'b0);
        end
    endtask

    // monitor: every pulse must match the next expected event, cycle-exact
    always @(negedge clk) begin
        hdr_e_t h;
        pl_e_t  p;
        out_e_t o;
        if (bus.hdr_valid === 1'b1) begin
            if (hq.size() == 0) chk("hdr_unexpected", 1, 0);
            else begin
                h = hq.pop_front();
                chk("hdr_cyc", cyc, h.cyc);
                chk("hdr_type", int'(bus.frame_type), int'(h.typ));
                chk("hdr_txfn", int'(bus.txfn), int'(h.fn));
                chk("hdr_len", int'(bus.payload_len), int'(h.len));
            end
        end
        if (bus.payload_valid === 1'b1) begin
            pl_count++;
            if (pq.size() == 0) chk("pl_unexpected", 1, 0);
            else begin
                p = pq.pop_front();
                chk("pl_cyc", cyc, p.cyc);
                chk("pl_data", int'(bus.payload_data), int'(p.d));
            end
        end
        if (bus.frame_ok === 1'b1 || bus.frame_err === 1'b1) begin
            chk("one_outcome", int'(bus.frame_ok & bus.frame_err), 0);
            if (oq.size() == 0) chk("out_unexpected", 1, 0);
            else begin
                o = oq.pop_front();
                chk("out_cyc", cyc, o.cyc);
                chk("out_ok", int'(bus.frame_ok), int'(o.ok));
                if (!o.ok) chk("out_err_code", int'(bus.err_code), int'(o.code));
                else       chk("out_seq_err", int'(bus.seq_err), int'(o.seq));
                chk("out_ok_cnt", int'(bus.ok_cnt), o.okc);
                chk("out_err_cnt", int'(bus.err_cnt), o.errc);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: stimulus did not complete, cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] s9 [9];
        logic [7:0] nz [6];
        logic [15:0] c;
        int p0, e;
        s9 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        nz = '{8'h55, 8'h1A, 8'hCF, 8'hFC, 8'h00, 8'h77};
        bus.frame_valid = 1'b0;
        bus.frame_data  = 8'h00;

        // pin the CRC model: CCITT-FALSE check value
        c = 16'hFFFF;
        for (int i = 0; i < 9; i++) c = m_crc(c, s9[i]);
        chk("model_crc_check", int'(c), 32'h29B1);

        do_reset();

        // single good frame
        send_frame(8'h01, 16'h1000, 16'd100, -1, -1, 0, -1);
        idle(3);
        chk("t1_ok_cnt", int'(bus.ok_cnt), 1);
        chk("t1_payloads", pl_count, 100);
        chk("t1_txfn", int'(bus.txfn), 32'h1000);
        chk("t1_type", int'(bus.frame_type), 1);

        // three back-to-back frames
        do_reset();
        p0 = pl_count;
        send_frame(8'h01, 16'h1000, 16'd100,  -1, -1, 0, -1);
        send_frame(8'h01, 16'h1001, 16'd1052, -1, -1, 0, -1);
        send_frame(8'h01, 16'h1003, 16'd0,    -1, -1, 0, -1);
        idle(3);
        chk("t2_payloads", pl_count - p0, 1152);
        chk("t2_ok_cnt", int'(bus.ok_cnt), 3);
        chk("t2_seq_err_last", int'(bus.seq_err), 1);

        // corrupt payload byte 50
        p0 = pl_count;
        send_frame(8'h01, 16'h1004, 16'd100, 50, -1, 0, -1);
        idle(3);
        chk("t3_payloads", pl_count - p0, 100);
        chk("t3_err_code", int'(bus.err_code), 1);
        chk("t3_err_cnt", int'(bus.err_cnt), 1);
        chk("t3_ok_cnt", int'(bus.ok_cnt), 3);

        // header errors then a good frame
        p0 = pl_count;
        send_frame(8'h01, 16'h2000, 16'd1053, -1, -1, 0, -1);
        idle(2);
        chk("t4_len_code", int'(bus.err_code), 2);
        send_frame(8'h05, 16'h2001, 16'd10, -1, -1, 0, -1);
        idle(2);
        chk("t4_type_code", int'(bus.err_code), 3);
        chk("t4_no_payload", pl_count - p0, 0);
        send_frame(8'h02, 16'h1004, 16'd10, -1, -1, 0, -1);
        idle(2);
        chk("t4_err_cnt", int'(bus.err_cnt), 3);
        chk("t4_ok_cnt", int'(bus.ok_cnt), 4);

        // gap timeout boundary
        send_frame(8'h01, 16'h1005, 16'd20, -1, 5, 16, -1);
        send_frame(8'h01, 16'h1005, 16'd20, -1, 5, 15, -1);
        idle(2);
        chk("t5_err_cnt", int'(bus.err_cnt), 4);
        chk("t5_ok_cnt", int'(bus.ok_cnt), 5);

        // noise with a partial marker, then a true frame
        for (int i = 0; i < 6; i++) tick(1'b1, nz[i], e);
        send_frame(8'h03, 16'h1006, 16'd8, -1, -1, 0, -1);
        idle(2);
        chk("t6_ok_cnt", int'(bus.ok_cnt), 6);

        // reset mid-payload, then a fresh frame
        send_frame(8'h01, 16'h1007, 16'd30, -1, -1, 0, 10);
        idle(20);
        chk("t7_no_err", int'(bus.err_cnt), 0);
        send_frame(8'h01, 16'h1234, 16'd5, -1, -1, 0, -1);
        idle(5);
        chk("t7_ok_cnt", int'(bus.ok_cnt), 1);
        chk("t7_seq_err", int'(bus.seq_err), 0);

        chk("left_hdr", hq.size(), 0);
        chk("left_payload", pq.size(), 0);
        chk("left_outcome", oq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
